// File: rtl/config_loader_if.sv
// Host-side byte stream and tile configuration bus of the config loader.
// The loader itself connects through the slave modport; the host (or bench)
// drives start/stream and watches the bus through the master modport.
interface config_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] words_written;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, config_addr, config_data, busy, done, error, words_written
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, config_addr, config_data, busy, done, error, words_written
  );
endinterface

// File: rtl/config_loader.sv
// Configuration master for the tile array. Parses a little-endian byte
// bitstream (count, N x {addr, data}, XOR trailer) and replays each record
// as a word write held on config_addr/config_data for WRITE_CYCLES cycles.
// Every output is registered; reset forces the bus back to IDLE_ADDR
// asynchronously so a tile can never see a partial or stretched write.
module config_loader #(
  parameter int unsigned WRITE_CYCLES = 1,            // 1..15
  parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000 // block select 0 matches nothing
) (
  input  logic            clk,
  input  logic            reset,
  config_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_ADDR, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] WC_LAST = 4'(WRITE_CYCLES);

  state_t      state;
  logic [1:0]  byte_idx;   // position within the current 4-byte field
  logic [23:0] shift;      // earlier bytes of the field, first byte lowest
  logic [31:0] addr_q;     // address of the record being assembled
  logic [31:0] rec_left;   // records still to be written
  logic [7:0]  csum;       // XOR of every byte accepted so far
  logic [3:0]  wc_cnt;     // WRITE cycle number, 1-based

  logic        accept;
  logic        last_byte;
  logic [31:0] word;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = (byte_idx == 2'd3);
  // Complete little-endian word as it stands on the edge of its last byte.
  assign word      = {bus.in_data, shift};

  // Single FSM: byte assembly, checksum, write sequencing and all outputs.
  // NOTE: all state here uses <=, so every branch reads the values from
  // before this edge; e.g. the CHECK compare sees csum without the trailer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      byte_idx          <= '0;
      shift             <= '0;
      addr_q            <= '0;
      rec_left          <= '0;
      csum              <= '0;
      wc_cnt            <= '0;
      bus.in_ready      <= 1'b0;
      bus.config_addr   <= IDLE_ADDR;
      bus.config_data   <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
      bus.words_written <= '0;
    end else begin
      if (accept) begin
        csum     <= csum ^ bus.in_data;
        shift    <= {bus.in_data, shift[23:8]};
        byte_idx <= byte_idx + 2'd1;
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            state             <= S_COUNT;
            byte_idx          <= '0;
            csum              <= '0;
            bus.in_ready      <= 1'b1;
            bus.busy          <= 1'b1;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
            bus.words_written <= '0;
          end
        end

        S_COUNT: begin
          if (accept && last_byte) begin
            rec_left <= word;
            state    <= (word == 32'd0) ? S_CHECK : S_ADDR;
          end
        end

        S_ADDR: begin
          if (accept && last_byte) begin
            addr_q <= word;
            state  <= S_DATA;
          end
        end

        S_DATA: begin
          if (accept && last_byte) begin
            state           <= S_WRITE;
            wc_cnt          <= 4'd1;
            bus.in_ready    <= 1'b0;
            bus.config_addr <= addr_q;
            bus.config_data <= word;
          end
        end

        S_WRITE: begin
          if (wc_cnt == WC_LAST) begin
            bus.config_addr   <= IDLE_ADDR;
            bus.config_data   <= '0;
            bus.words_written <= bus.words_written + 32'd1;
            bus.in_ready      <= 1'b1;
            rec_left          <= rec_left - 32'd1;
            state             <= (rec_left == 32'd1) ? S_CHECK : S_ADDR;
          end else begin
            wc_cnt <= wc_cnt + 4'd1;
          end
        end

        S_CHECK: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            if (bus.in_data == csum) begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              bus.error <= 1'b1;
              state     <= S_ERR;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (WRITE_CYCLES 1 and 3) share the
// clock and reset; a select bit routes the host stream to one of them and
// muxes its outputs for checking. Expected writes and trailers come from the
// record list and a plain XOR over the generated byte stream.
module tb_config_loader;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  config_loader_if if1();
  config_loader_if if3();

  config_loader #(.WRITE_CYCLES(1), .IDLE_ADDR(IDLE)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  config_loader #(.WRITE_CYCLES(3), .IDLE_ADDR(IDLE)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  logic       sel = 1'b0;   // 0 -> dut1, 1 -> dut3
  logic       h_start = 1'b0;
  logic       h_valid = 1'b0;
  logic [7:0] h_data = 8'h00;

  assign if1.start    = h_start & ~sel;
  assign if3.start    = h_start & sel;
  assign if1.in_valid = h_valid & ~sel;
  assign if3.in_valid = h_valid & sel;
  assign if1.in_data  = h_data;
  assign if3.in_data  = h_data;

  logic        obs_ready, obs_busy, obs_done, obs_err;
  logic [31:0] obs_addr, obs_data, obs_ww;
  assign obs_ready = sel ? if3.in_ready      : if1.in_ready;
  assign obs_busy  = sel ? if3.busy          : if1.busy;
  assign obs_done  = sel ? if3.done          : if1.done;
  assign obs_err   = sel ? if3.error         : if1.error;
  assign obs_addr  = sel ? if3.config_addr   : if1.config_addr;
  assign obs_data  = sel ? if3.config_data   : if1.config_data;
  assign obs_ww    = sel ? if3.words_written : if1.words_written;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference: records, stream, expected writes ----------
  logic [31:0] rec_a[$];
  logic [31:0] rec_d[$];
  logic [7:0]  stream[$];

  task automatic make_records(input int n);
    rec_a.delete();
    rec_d.delete();
    for (int i = 0; i < n; i++) begin
      rec_a.push_back({16'($urandom_range(1, 65535)), 16'($urandom)});
      rec_d.push_back($urandom);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
  endtask

  task automatic build_stream(input logic [7:0] mask);
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    push_word(32'(rec_a.size()));
    foreach (rec_a[i]) begin
      push_word(rec_a[i]);
      push_word(rec_d[i]);
    end
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(x ^ mask);
  endtask

  // ---------------- bus monitor --------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          len;
    int          t0;
  } wr_t;

  wr_t seen[$];
  wr_t cur;
  int  run = 0;
  int  cyc = 0;
  bit  bus_bad = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (obs_addr !== IDLE) begin
      if (run == 0) begin
        cur.a  = obs_addr;
        cur.d  = obs_data;
        cur.t0 = cyc;
      end else if (obs_addr !== cur.a || obs_data !== cur.d) begin
        bus_bad = 1'b1;
      end
      if (obs_ready !== 1'b0) bus_bad = 1'b1;
      run++;
    end else begin
      if (obs_data !== 32'h0) bus_bad = 1'b1;
      if (run != 0) begin
        cur.len = run;
        seen.push_back(cur);
        run = 0;
      end
    end
  end

  task automatic clear_mon();
    #1;
    seen.delete();
    run     = 0;
    bus_bad = 1'b0;
  endtask

  // ---------------- host driver ------------------------------------------
  task automatic pulse_start();
    clear_mon();
    @(negedge clk);
    h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0;
    check("start.in_ready", 32'(obs_ready), 32'd1);
    check("start.busy",     32'(obs_busy),  32'd1);
    check("start.done",     32'(obs_done),  32'd0);
    check("start.error",    32'(obs_err),   32'd0);
    check("start.words",    obs_ww,         32'd0);
  endtask

  // Sends the first n_bytes of the stream; optional start pulse alongside
  // byte pulse_idx; final_chk checks the flags the cycle after the trailer.
  task automatic send(input int n_bytes, input bit gaps, input int pulse_idx, input bit final_chk);
    int idx;
    int n;
    bit took;
    idx = 0;
    n   = 0;
    while (idx < n_bytes && n < 3000) begin
      @(negedge clk);
      h_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      h_data  = stream[idx];
      h_start = (idx == pulse_idx);
      took    = h_valid && obs_ready;
      @(posedge clk);
      if (took) idx++;
      n++;
    end
    #1;
    h_valid = 1'b0;
    h_start = 1'b0;
    if (idx != n_bytes) check("send.timeout", 32'(idx), 32'(n_bytes));
    if (final_chk) begin
      @(negedge clk);
      check("end.flag", 32'(obs_done | obs_err), 32'd1);
      check("end.busy", 32'(obs_busy), 32'd0);
    end
  endtask

  task automatic check_load(input string tag, input bit exp_ok, input int wc);
    repeat (2) @(negedge clk);
    #1;
    check({tag, ".done"},   32'(obs_done), 32'(exp_ok));
    check({tag, ".error"},  32'(obs_err),  32'(!exp_ok));
    check({tag, ".busy"},   32'(obs_busy), 32'd0);
    check({tag, ".words"},  obs_ww,        32'(rec_a.size()));
    check({tag, ".nwr"},    32'(seen.size()), 32'(rec_a.size()));
    check({tag, ".bus_ok"}, 32'(bus_bad),  32'd0);
    for (int i = 0; i < seen.size() && i < rec_a.size(); i++) begin
      check({tag, ".addr"}, seen[i].a, rec_a[i]);
      check({tag, ".data"}, seen[i].d, rec_d[i]);
      check({tag, ".hold"}, 32'(seen[i].len), 32'(wc));
    end
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(obs_ready), 32'd0);
    check("rst.addr",     obs_addr,       IDLE);
    check("rst.data",     obs_data,       32'd0);
    check("rst.busy",     32'(obs_busy),  32'd0);
    check("rst.done",     32'(obs_done),  32'd0);
    check("rst.error",    32'(obs_err),   32'd0);
    check("rst.words",    obs_ww,         32'd0);
    sel = 1'b1;
    #1;
    check("rst3.addr",     obs_addr,       IDLE);
    check("rst3.in_ready", 32'(obs_ready), 32'd0);
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Single fixed record, WRITE_CYCLES=1.
    rec_a = {32'h0004_0003};
    rec_d = {32'h0000_0002};
    build_stream(8'h00);
    pulse_start();
    send(stream.size(), 1'b0, -1, 1'b1);
    check_load("single", 1'b1, 1);

    // Zero-count load.
    rec_a.delete();
    rec_d.delete();
    build_stream(8'h00);
    check("zero.trailer", 32'(stream[4]), 32'h0);
    pulse_start();
    send(stream.size(), 1'b0, -1, 1'b1);
    check_load("zero", 1'b1, 1);

    // Bad checksum with two records; also back-to-back write spacing.
    make_records(2);
    build_stream(8'h01);
    pulse_start();
    send(stream.size(), 1'b0, -1, 1'b1);
    check_load("badsum", 1'b0, 1);
    if (seen.size() >= 2) check("badsum.spacing", 32'(seen[1].t0 - seen[0].t0), 32'd9);

    // Start pulsed while in DATA (alongside the first data byte).
    make_records(3);
    build_stream(8'h00);
    pulse_start();
    send(stream.size(), 1'b0, 8, 1'b1);
    check_load("busystart", 1'b1, 1);
    pulse_start();   // a fresh start clears done and words_written

    // WRITE_CYCLES=3: same records gap-free, then with in_valid gaps.
    sel = 1'b1;
    make_records(3);
    build_stream(8'h00);
    pulse_start();
    send(stream.size(), 1'b0, -1, 1'b1);
    check_load("wc3.nogap", 1'b1, 3);
    pulse_start();
    send(stream.size(), 1'b1, -1, 1'b1);
    check_load("wc3.gaps", 1'b1, 3);

    // Random loads with gaps, some with a corrupted trailer.
    for (int it = 0; it < 3; it++) begin
      logic [7:0] mask;
      mask = ($urandom_range(0, 1) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      make_records($urandom_range(1, 4));
      build_stream(mask);
      pulse_start();
      send(stream.size(), 1'b1, -1, 1'b1);
      check_load("rnd", mask == 8'h00, 3);
    end

    // Reset during the second of three WRITE cycles, then full reload.
    make_records(2);
    build_stream(8'h00);
    pulse_start();
    send(12, 1'b0, -1, 1'b0);
    @(negedge clk);
    check("rstw.cycle1", obs_addr, rec_a[0]);
    @(negedge clk);
    check("rstw.cycle2", obs_addr, rec_a[0]);
    #1;
    reset = 1'b1;
    #1;
    check("rstw.addr",     obs_addr,       IDLE);
    check("rstw.data",     obs_data,       32'd0);
    check("rstw.in_ready", 32'(obs_ready), 32'd0);
    check("rstw.busy",     32'(obs_busy),  32'd0);
    check("rstw.done",     32'(obs_done),  32'd0);
    check("rstw.error",    32'(obs_err),   32'd0);
    check("rstw.words",    obs_ww,         32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start();
    send(stream.size(), 1'b1, -1, 1'b1);
    check_load("reload", 1'b1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
